nn_layer_sequencer: RTL and testbench

Control FSM that runs a multi-layer inference on the NeuralNetwork datapath. It issues one layer at a time to the shared layer compute unit and supplies that layer's input and output neuron counts. It alternates the ping-pong activation buffers between layers and reports completion or a configuration or timeout error. It sits between the top-level host or testbench and the layer datapath.

---
 rtl/nn_layer_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_nn_layer_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer
// Control FSM that runs a multi-layer inference on the shared layer compute
// unit. It validates the per-layer neuron counts, issues one layer at a time,
// alternates the ping-pong activation buffers between layers, and reports
// completion, a configuration error or a layer timeout through error_code.
module nn_layer_sequencer #(
    parameter int NR_LAYERS = 2,
    parameter int IN_SIZE   = 4,
    parameter int OUT_SIZE  = 10,
    parameter int MAX_IN    = 4,
    parameter int MAX_OUT   = 10,
    parameter int TIMEOUT   = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [32*NR_LAYERS-1:0] neuron_count,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              error_code,
    output logic                    layer_start,
    input  logic                    layer_done,
    output logic [31:0]             layer_idx,
    output logic [31:0]             layer_in_count,
    output logic [31:0]             layer_out_count,
    output logic                    src_buf,
    output logic                    result_buf
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_WAIT,
        S_FINISH,
        S_ERR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_RANGE   = 2'd1,
        ERR_LAST    = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_t;

    localparam logic [31:0] IN_SIZE_W  = 32'(IN_SIZE);
    localparam logic [31:0] OUT_SIZE_W = 32'(OUT_SIZE);
    localparam logic [31:0] MAX_IN_W   = 32'(MAX_IN);
    localparam logic [31:0] MAX_OUT_W  = 32'(MAX_OUT);
    localparam logic [31:0] LAST_IDX   = 32'(NR_LAYERS - 1);
    // Counter value in the WAIT cycle whose increment lands on TIMEOUT-1;
    // without layer_done in that cycle the run aborts on the next edge, so
    // ERR is entered exactly TIMEOUT cycles after the layer_start cycle.
    localparam logic [31:0] TMO_LAST   = 32'(TIMEOUT - 2);

    // Registered state and its next-state values
    state_t                  state_q, state_d;
    logic [32*NR_LAYERS-1:0] cfg_q,   cfg_d;
    err_t                    err_q,   err_d;
    logic [31:0]             idx_q,   idx_d;
    logic [31:0]             in_q,    in_d;
    logic [31:0]             out_q,   out_d;
    logic [31:0]             tmo_q,   tmo_d;
    logic                    src_q,   src_d;
    logic                    res_q,   res_d;

    // Per-layer counts derived from the latched configuration
    logic [31:0] cfg_in  [NR_LAYERS];
    logic [31:0] cfg_out [NR_LAYERS];
    logic        range_bad;
    logic        last_bad;
    logic [31:0] next_idx;
    logic [31:0] sel_in;
    logic [31:0] sel_out;

    // Layer k reads the outputs of layer k-1; layer 0 reads the input vector.
    for (genvar k = 0; k < NR_LAYERS; k++) begin : g_counts
        assign cfg_out[k] = cfg_q[32*k +: 32];
        if (k == 0) begin : g_first
            assign cfg_in[k] = IN_SIZE_W;
        end else begin : g_rest
            assign cfg_in[k] = cfg_q[32*(k-1) +: 32];
        end
    end

    // Configuration checks: per-layer range, then last-layer width.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        range_bad = 1'b0;
        for (int k = 0; k < NR_LAYERS; k++) begin
            if (cfg_out[k] == '0 || cfg_out[k] > MAX_OUT_W || cfg_in[k] > MAX_IN_W) begin
                range_bad = 1'b1;
            end
        end
        last_bad = (cfg_out[NR_LAYERS-1] != OUT_SIZE_W);
    end

    // Index of the layer about to be issued and its counts; depends only on
    // registered state so the main next-state block stays loop-free.
    always_comb begin
        next_idx = (state_q == S_WAIT) ? idx_q + 32'd1 : 32'd0;
        sel_in   = '0;
        sel_out  = '0;
        for (int k = 0; k < NR_LAYERS; k++) begin
            if (next_idx == 32'(k)) begin
                sel_in  = cfg_in[k];
                sel_out = cfg_out[k];
            end
        end
    end

    // Next-state and datapath update logic for the sequencer.
    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        err_d   = err_q;
        idx_d   = idx_q;
        in_d    = in_q;
        out_d   = out_q;
        tmo_d   = tmo_q;
        src_d   = src_q;
        res_d   = res_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cfg_d   = neuron_count;
                    err_d   = ERR_NONE;
                    state_d = S_CHECK;
                end
            end

            S_CHECK: begin
                if (range_bad) begin
                    err_d   = ERR_RANGE;
                    state_d = S_ERR;
                end else if (last_bad) begin
                    err_d   = ERR_LAST;
                    state_d = S_ERR;
                end else begin
                    idx_d   = next_idx;
                    src_d   = 1'b0;
                    in_d    = sel_in;
                    out_d   = sel_out;
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                tmo_d = tmo_q + 32'd1;
                // layer_done takes priority over a coincident timeout
                if (layer_done) begin
                    if (idx_q == LAST_IDX) begin
                        res_d   = ~src_q;
                        state_d = S_FINISH;
                    end else begin
                        idx_d   = next_idx;
                        src_d   = ~src_q;
                        in_d    = sel_in;
                        out_d   = sel_out;
                        state_d = S_ISSUE;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = S_ERR;
                end
            end

            S_FINISH, S_ERR: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the latched configuration and counters are reset along
            // with the FSM so a mid-run reset leaves no stale run state.
            state_q <= S_IDLE;
            cfg_q   <= '0;
            err_q   <= ERR_NONE;
            idx_q   <= '0;
            in_q    <= '0;
            out_q   <= '0;
            tmo_q   <= '0;
            src_q   <= 1'b0;
            res_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q <= state_d;
            cfg_q   <= cfg_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            in_q    <= in_d;
            out_q   <= out_d;
            tmo_q   <= tmo_d;
            src_q   <= src_d;
            res_q   <= res_d;
        end
    end

    assign busy            = (state_q != S_IDLE);
    assign done            = (state_q == S_FINISH) || (state_q == S_ERR);
    assign layer_start     = (state_q == S_ISSUE);
    assign error_code      = err_q;
    assign layer_idx       = idx_q;
    assign layer_in_count  = in_q;
    assign layer_out_count = out_q;
    assign src_buf         = src_q;
    assign result_buf      = res_q;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Self-checking bench for nn_layer_sequencer: table-driven vectors, random
// runs scored against a behavioural timeline model, and hand-written
// sequences for reset mid-run and start held high.
module tb_nn_layer_sequencer;

    localparam int NL     = 2;
    localparam int IN_SZ  = 4;
    localparam int OUT_SZ = 10;
    localparam int MAX_I  = 4;
    localparam int MAX_O  = 10;
    localparam int TMO    = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            layer_done = 1'b0;
    logic [32*NL-1:0] neuron_count = '0;
    logic            busy, done, layer_start, src_buf, result_buf;
    logic [1:0]      error_code;
    logic [31:0]     layer_idx, layer_in_count, layer_out_count;

    int   n_checks = 0;
    int   n_errors = 0;
    logic [1:0] prev_code = 2'd0;
    logic       prev_res  = 1'b0;

    typedef struct {
        logic [32*NL-1:0] nc;
        int               dly [NL];
        logic [1:0]       cfg_code;
    } vec_t;

    nn_layer_sequencer #(
        .NR_LAYERS(NL), .IN_SIZE(IN_SZ), .OUT_SIZE(OUT_SZ),
        .MAX_IN(MAX_I), .MAX_OUT(MAX_O), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .neuron_count(neuron_count),
        .busy(busy), .done(done), .error_code(error_code),
        .layer_start(layer_start), .layer_done(layer_done),
        .layer_idx(layer_idx), .layer_in_count(layer_in_count),
        .layer_out_count(layer_out_count), .src_buf(src_buf),
        .result_buf(result_buf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] l1, input logic [31:0] l0,
                                input int d0, input int d1, input logic [1:0] code);
        vec_t v;
        v.nc       = {l1, l0};
        v.dly[0]   = d0;
        v.dly[1]   = d1;
        v.cfg_code = code;
        return v;
    endfunction

    // Reference rule for a configuration: range problems outrank a wrong
    // final width.
    function automatic logic [1:0] model_code(input logic [32*NL-1:0] nc);
        longint unsigned outs [NL];
        longint unsigned ins  [NL];
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < NL; k++) outs[k] = nc[32*k +: 32];
        for (int k = 0; k < NL; k++) begin
            if (k == 0) ins[k] = IN_SZ;
            else        ins[k] = outs[k-1];
            if (outs[k] == 0 || outs[k] > MAX_O || ins[k] > MAX_I) bad = 1'b1;
        end
        if (bad) return 2'd1;
        if (outs[NL-1] != OUT_SZ) return 2'd2;
        return 2'd0;
    endfunction

    // Runs one inference, acting as the layer unit with the given per-layer
    // latencies, and checks every cycle against the predicted timeline.
    task automatic run_vec(input vec_t v, input string tag);
        int          t_iss [NL];
        int          t_dn  [NL];
        logic [31:0] ins   [NL];
        logic [31:0] outs  [NL];
        int          n_run, done_cyc, t, cur;
        logic [1:0]  code;
        logic        exp_res, stop, is_iss, is_dn, noise;

        for (int k = 0; k < NL; k++) begin
            outs[k]  = v.nc[32*k +: 32];
            if (k == 0) ins[k] = 32'(IN_SZ);
            else        ins[k] = outs[k-1];
            t_iss[k] = -1;
            t_dn[k]  = -1;
        end

        code     = v.cfg_code;
        n_run    = 0;
        t        = 2;
        done_cyc = 2;
        stop     = 1'b0;
        if (code == 2'd0) begin
            for (int k = 0; k < NL; k++) begin
                if (!stop) begin
                    t_iss[k] = t;
                    n_run    = k + 1;
                    if (v.dly[k] >= TMO) begin
                        code     = 2'd3;
                        done_cyc = t + TMO;
                        stop     = 1'b1;
                    end else begin
                        t_dn[k]  = t + v.dly[k];
                        t        = t + v.dly[k] + 1;
                        done_cyc = t;
                    end
                end
            end
        end
        exp_res = (((NL - 1) % 2) == 0);

        for (int c = 0; c <= done_cyc; c++) begin
            is_iss = 1'b0;
            is_dn  = 1'b0;
            cur    = -1;
            for (int k = 0; k < n_run; k++) begin
                if (c == t_iss[k]) is_iss = 1'b1;
                if (c == t_dn[k])  is_dn  = 1'b1;
                if (c >= t_iss[k]) cur = k;
            end
            noise        = (c <= 1) || is_iss || (c == done_cyc);
            start        = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            neuron_count = (c == 0) ? v.nc : {$urandom(), $urandom()};
            layer_done   = is_dn ? 1'b1 : (noise ? 1'($urandom_range(0, 1)) : 1'b0);

            @(negedge clk);
            check($sformatf("%s c%0d busy", tag, c), busy, (c >= 1));
            check($sformatf("%s c%0d done", tag, c), done, (c == done_cyc));
            check($sformatf("%s c%0d layer_start", tag, c), layer_start, is_iss);
            check($sformatf("%s c%0d error_code", tag, c), error_code,
                  (c == 0) ? prev_code : ((c < done_cyc) ? 2'd0 : code));
            check($sformatf("%s c%0d result_buf", tag, c), result_buf,
                  (c >= done_cyc && code == 2'd0) ? exp_res : prev_res);
            if (cur >= 0) begin
                check($sformatf("%s c%0d layer_idx", tag, c), layer_idx, 32'(cur));
                check($sformatf("%s c%0d in_count", tag, c), layer_in_count, ins[cur]);
                check($sformatf("%s c%0d out_count", tag, c), layer_out_count, outs[cur]);
                check($sformatf("%s c%0d src_buf", tag, c), src_buf, 32'(cur % 2));
            end
            @(posedge clk);
            #1;
        end

        prev_code = code;
        if (code == 2'd0) prev_res = exp_res;

        start      = 1'b0;
        layer_done = 1'b0;
        @(negedge clk);
        check($sformatf("%s idle busy", tag), busy, 1'b0);
        check($sformatf("%s idle done", tag), done, 1'b0);
        check($sformatf("%s idle error_code", tag), error_code, code);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t       tbl [$];
        vec_t       rv;
        logic [7:0] exp_busy;
        logic [7:0] exp_done;

        // Reset with start and layer_done active must still leave everything zero
        rst_n        = 1'b0;
        start        = 1'b1;
        layer_done   = 1'b1;
        neuron_count = {32'd10, 32'd3};
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset layer_start", layer_start, 1'b0);
        check("reset error_code", error_code, 2'd0);
        check("reset layer_idx", layer_idx, 32'd0);
        check("reset in_count", layer_in_count, 32'd0);
        check("reset out_count", layer_out_count, 32'd0);
        check("reset src_buf", src_buf, 1'b0);
        check("reset result_buf", result_buf, 1'b0);
        rst_n      = 1'b1;
        start      = 1'b0;
        layer_done = 1'b0;
        @(posedge clk);
        #1;

        // Table of directed vectors: {layer1, layer0}, latencies, config code
        tbl.push_back(mk(32'd10, 32'd3, 5, 5, 2'd0));          // nominal
        tbl.push_back(mk(32'd10, 32'd0, 1, 1, 2'd1));          // zero neurons
        tbl.push_back(mk(32'd10, 32'd5, 1, 1, 2'd1));          // layer1 input > MAX_IN
        tbl.push_back(mk(32'd9,  32'd3, 1, 1, 2'd2));          // last width wrong
        tbl.push_back(mk(32'd10, 32'd3, 3, 4, 2'd0));          // clears error_code
        tbl.push_back(mk(32'd10, 32'd11, 1, 1, 2'd1));         // out > MAX_OUT
        tbl.push_back(mk(32'd11, 32'd3, 1, 1, 2'd1));          // range beats width
        tbl.push_back(mk(32'd0,  32'd4, 1, 1, 2'd1));          // last layer empty
        tbl.push_back(mk(32'd10, 32'd4, TMO - 1, 1, 2'd0));    // done on last count
        tbl.push_back(mk(32'd10, 32'd3, TMO, 1, 2'd0));        // timeout layer 0
        tbl.push_back(mk(32'd10, 32'd2, 1, TMO + 4, 2'd0));    // timeout layer 1
        tbl.push_back(mk(32'd10, 32'd1, TMO - 1, TMO - 1, 2'd0));
        tbl.push_back(mk(32'd10, 32'h8000_0000, 1, 1, 2'd1));  // huge count
        tbl.push_back(mk(32'hFFFF_FFFF, 32'd3, 1, 1, 2'd1));
        tbl.push_back(mk(32'd10, 32'd4, TMO - 2, 2, 2'd0));
        foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Randomized runs against the reference rule
        for (int r = 0; r < 40; r++) begin
            rv.nc[31:0]  = 32'($urandom_range(0, 6));
            rv.nc[63:32] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 12)) : 32'd10;
            rv.dly[0]    = $urandom_range(1, TMO + 2);
            rv.dly[1]    = $urandom_range(1, TMO + 2);
            rv.cfg_code  = model_code(rv.nc);
            run_vec(rv, $sformatf("rnd%0d", r));
        end

        // start held high relaunches on every return to IDLE
        exp_busy     = 8'b0011_0110;
        exp_done     = 8'b0010_0100;
        neuron_count = {32'd10, 32'd0};
        for (int c = 0; c < 8; c++) begin
            start = (c <= 5);
            @(negedge clk);
            check($sformatf("held c%0d busy", c), busy, exp_busy[c]);
            check($sformatf("held c%0d done", c), done, exp_done[c]);
            if (c == 5) check("held error_code", error_code, 2'd1);
            @(posedge clk);
            #1;
        end
        prev_code = 2'd1;

        // Reset during layer 1 WAIT aborts without a done pulse
        start        = 1'b1;
        neuron_count = {32'd10, 32'd3};
        for (int c = 0; c < 8; c++) begin
            if (c == 1) start = 1'b0;
            layer_done = (c == 4);
            if (c == 7) rst_n = 1'b0;
            @(negedge clk);
            if (c == 5) begin
                check("rstrun layer_start", layer_start, 1'b1);
                check("rstrun layer_idx", layer_idx, 32'd1);
            end
            @(posedge clk);
            #1;
        end
        rst_n      = 1'b1;
        layer_done = 1'b0;
        @(negedge clk);
        check("midrst busy", busy, 1'b0);
        check("midrst done", done, 1'b0);
        check("midrst layer_start", layer_start, 1'b0);
        check("midrst error_code", error_code, 2'd0);
        check("midrst layer_idx", layer_idx, 32'd0);
        check("midrst in_count", layer_in_count, 32'd0);
        check("midrst out_count", layer_out_count, 32'd0);
        check("midrst src_buf", src_buf, 1'b0);
        check("midrst result_buf", result_buf, 1'b0);
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("postrst c%0d done", c), done, 1'b0);
            check($sformatf("postrst c%0d busy", c), busy, 1'b0);
            @(posedge clk);
            #1;
        end
        prev_code = 2'd0;
        prev_res  = 1'b0;
        run_vec(mk(32'd10, 32'd3, 2, 3, 2'd0), "fresh");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
